// File: rtl/pipe_data_path.sv
`timescale 1ns/1ps
// pipe_data_path: 3-stage issue/operand/execute datapath, NREG x DWIDTH
// register file, full forwarding, PC. Optional flags: PIPE_DP_FLAGS_EN.
module pipe_data_path #(
    parameter int DWIDTH = 16,
    parameter int RADDR  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic [RADDR-1:0]  rd,
    input  logic [RADDR-1:0]  rs,
    input  logic              wr_en,
    input  logic              alu_in_sel,
    input  logic [7:0]        offset,
    input  logic [2:0]        alu_func,
    input  logic              en_pc_pulse,
    input  logic [1:0]        pc_ctrl,
    input  logic [7:0]        offset_addr,
    output logic [DWIDTH-1:0] pc_out,
    output logic              en_out,
    output logic [DWIDTH-1:0] alu_out,
    input  logic [RADDR-1:0]  dbg_addr,
    output logic [DWIDTH-1:0] dbg_data
`ifdef PIPE_DP_FLAGS_EN
    ,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n
`endif
);
    localparam int NREG = 1 << RADDR;

    typedef struct packed {
        logic [RADDR-1:0] rd;
        logic [RADDR-1:0] rs;
        logic             wr;
        logic             sel;
        logic [7:0]       off;
        logic [2:0]       func;
    } if_id_t;

    typedef struct packed {
        logic [RADDR-1:0]  rd;
        logic              wr;
        logic [2:0]        func;
        logic [DWIDTH-1:0] a;
        logic [DWIDTH-1:0] b;
    } id_ex_t;

    logic              r_s1_v;
    logic              r_s2_v;
    logic              r_s3_v;
    if_id_t            r_s1;
    id_ex_t            r_s2;
    logic [RADDR-1:0]  r_s3_rd;
    logic              r_s3_wr;
    logic [DWIDTH-1:0] r_alu;
    logic [DWIDTH-1:0] r_pc;
    logic [DWIDTH-1:0] r_regs [NREG];

    logic [DWIDTH-1:0] w_a;
    logic [DWIDTH-1:0] w_b;
    logic [DWIDTH-1:0] w_alu;
    logic [DWIDTH-1:0] w_sext;

    assign w_sext = DWIDTH'($signed(r_s1.off));

    // Operand resolve: youngest in-flight producer beats the register file
    always_comb begin
        w_a = r_regs[r_s1.rd];
        if (r_s2_v && r_s2.wr && r_s2.rd == r_s1.rd)
            w_a = w_alu;
        else if (r_s3_v && r_s3_wr && r_s3_rd == r_s1.rd)
            w_a = r_alu;
        w_b = r_regs[r_s1.rs];
        if (r_s2_v && r_s2.wr && r_s2.rd == r_s1.rs)
            w_b = w_alu;
        else if (r_s3_v && r_s3_wr && r_s3_rd == r_s1.rs)
            w_b = r_alu;
        if (r_s1.sel)
            w_b = w_sext;
    end

    // Execute-stage ALU on registered operands
    always_comb begin
        w_alu = '0;
        unique case (r_s2.func)
            3'b000: w_alu = r_s2.a + r_s2.b;
            3'b001: w_alu = r_s2.a - r_s2.b;
            3'b010: w_alu = r_s2.a & r_s2.b;
            3'b011: w_alu = r_s2.a | r_s2.b;
            3'b100: w_alu = r_s2.a ^ r_s2.b;
            3'b101: w_alu = ~r_s2.a;
            3'b110: w_alu = r_s2.b;
            3'b111: w_alu = (r_s2.a < r_s2.b) ? DWIDTH'(1) : '0;
        endcase
    end

    // Pipeline registers; bubbles hold data and only clear the valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v  <= 1'b0;
            r_s2_v  <= 1'b0;
            r_s3_v  <= 1'b0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3_rd <= '0;
            r_s3_wr <= 1'b0;
            r_alu   <= '0;
        end else begin
            r_s1_v <= en_in;
            if (en_in)
                r_s1 <= '{rd: rd, rs: rs, wr: wr_en, sel: alu_in_sel,
                          off: offset, func: alu_func};
            r_s2_v <= r_s1_v;
            if (r_s1_v)
                r_s2 <= '{rd: r_s1.rd, wr: r_s1.wr, func: r_s1.func,
                          a: w_a, b: w_b};
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
                r_s3_rd <= r_s2.rd;
                r_s3_wr <= r_s2.wr;
                r_alu   <= w_alu;
            end
        end
    end

    // Writeback of the result currently presented on alu_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (r_s3_v && r_s3_wr) begin
            r_regs[r_s3_rd] <= r_alu;
        end
    end

    // Program counter, independent of instruction issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (en_pc_pulse) begin
            unique case (pc_ctrl)
                2'b00: r_pc <= r_pc;
                2'b01: r_pc <= r_pc + DWIDTH'(1);
                2'b10: r_pc <= DWIDTH'(offset_addr);
                2'b11: r_pc <= r_pc + DWIDTH'($signed(offset_addr));
            endcase
        end
    end

`ifdef PIPE_DP_FLAGS_EN
    logic r_fz;
    logic r_fc;
    logic r_fn;
    logic w_c;

    // ADD carries exactly when the wrapped sum is below an operand
    always_comb begin
        w_c = 1'b0;
        if (r_s2.func == 3'b000)
            w_c = (w_alu < r_s2.a);
        else if (r_s2.func == 3'b001)
            w_c = (r_s2.a < r_s2.b);
    end

    // Flags move together with alu_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fz <= 1'b0;
            r_fc <= 1'b0;
            r_fn <= 1'b0;
        end else if (r_s2_v) begin
            r_fz <= (w_alu == '0);
            r_fc <= w_c;
            r_fn <= w_alu[DWIDTH-1];
        end
    end

    assign flag_z = r_fz;
    assign flag_c = r_fc;
    assign flag_n = r_fn;
`endif

    assign pc_out   = r_pc;
    assign en_out   = r_s3_v;
    assign alu_out  = r_alu;
    assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_pipe_data_path.sv
`timescale 1ns/1ps
// tb_pipe_data_path: directed and randomized checks of pipe_data_path
// against an in-order architectural model.
module tb_pipe_data_path;
    localparam int DW = 16;
    localparam int RA = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_in;
    logic [RA-1:0] rd;
    logic [RA-1:0] rs;
    logic          wr_en;
    logic          alu_in_sel;
    logic [7:0]    offset;
    logic [2:0]    alu_func;
    logic          en_pc_pulse;
    logic [1:0]    pc_ctrl;
    logic [7:0]    offset_addr;
    logic [DW-1:0] pc_out;
    logic          en_out;
    logic [DW-1:0] alu_out;
    logic [RA-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
`ifdef PIPE_DP_FLAGS_EN
    logic          flag_z;
    logic          flag_c;
    logic          flag_n;
`endif

    pipe_data_path #(.DWIDTH(DW), .RADDR(RA)) dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .rd(rd), .rs(rs),
        .wr_en(wr_en), .alu_in_sel(alu_in_sel), .offset(offset),
        .alu_func(alu_func), .en_pc_pulse(en_pc_pulse),
        .pc_ctrl(pc_ctrl), .offset_addr(offset_addr), .pc_out(pc_out),
        .en_out(en_out), .alu_out(alu_out), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
`ifdef PIPE_DP_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] m_reg [4];
    logic [DW-1:0] m_pc;
    int            q_due [$];
    logic [DW-1:0] q_res [$];

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] f,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return b;
            default: return (a < b) ? 16'd1 : 16'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_pc = '0;
        q_due.delete();
        q_res.delete();
    endtask

    // Drive one instruction; the model executes it in program order.
    task automatic drive_op(input logic [1:0] d, input logic [1:0] s,
                            input logic w, input logic sl,
                            input logic [7:0] off, input logic [2:0] f);
        logic [DW-1:0] a, b, r;
        en_in = 1'b1; rd = d; rs = s; wr_en = w;
        alu_in_sel = sl; offset = off; alu_func = f;
        a = m_reg[d];
        b = sl ? {{8{off[7]}}, off} : m_reg[s];
        r = ref_alu(f, a, b);
        if (w) m_reg[d] = r;
        q_due.push_back(cyc + 3);
        q_res.push_back(r);
    endtask

    task automatic drive_pc(input logic p, input logic [1:0] c,
                            input logic [7:0] oa);
        en_pc_pulse = p; pc_ctrl = c; offset_addr = oa;
        if (p) begin
            case (c)
                2'd1: m_pc = m_pc + 16'd1;
                2'd2: m_pc = {8'h00, oa};
                2'd3: m_pc = m_pc + {{8{oa[7]}}, oa};
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        tick(); tick();
        checks++;
        if (pc_out !== 16'h0) begin
            errors++; $display("FAIL reset_pc got %h exp 0000", pc_out);
        end
        checks++;
        if (en_out !== 1'b0) begin
            errors++; $display("FAIL reset_en got %b exp 0", en_out);
        end
        checks++;
        if (alu_out !== 16'h0) begin
            errors++; $display("FAIL reset_alu got %h exp 0000", alu_out);
        end
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            checks++;
            if (dbg_data !== 16'h0) begin
                errors++;
                $display("FAIL reset_dbg r%0d got %h exp 0000", a, dbg_data);
            end
        end
    endtask

    task automatic test_single_pass();
        int n0;
        n0 = cyc;
        dbg_addr = 2'd1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) drive_op(2'd1, 2'd0, 1'b1, 1'b1, 8'hF6, 3'b110);
            else en_in = 1'b0;
            tick();
            checks++;
            if (en_out !== (cyc == n0 + 3)) begin
                errors++;
                $display("FAIL single_en c%0d got %b", cyc - n0, en_out);
            end
            if (cyc == n0 + 3) begin
                checks++;
                if (alu_out !== 16'hFFF6) begin
                    errors++;
                    $display("FAIL single_alu got %h exp fff6", alu_out);
                end
                checks++;
                if (dbg_data !== 16'h0) begin
                    errors++;
                    $display("FAIL single_dbg_early got %h exp 0000", dbg_data);
                end
            end
            if (cyc == n0 + 4) begin
                checks++;
                if (dbg_data !== 16'hFFF6) begin
                    errors++;
                    $display("FAIL single_dbg got %h exp fff6", dbg_data);
                end
            end
        end
        q_due.delete(); q_res.delete();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_v [4];
        int n0;
        exp_v = '{16'h0005, 16'h0003, 16'h0008, 16'h0005};
        n0 = cyc;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: drive_op(2'd1, 2'd0, 1'b1, 1'b1, 8'h05, 3'b110);
                1: drive_op(2'd2, 2'd0, 1'b1, 1'b1, 8'h03, 3'b110);
                2: drive_op(2'd1, 2'd2, 1'b1, 1'b0, 8'h00, 3'b000);
                3: drive_op(2'd1, 2'd2, 1'b1, 1'b0, 8'h00, 3'b001);
                default: en_in = 1'b0;
            endcase
            tick();
            checks++;
            if (en_out !== (cyc >= n0 + 3 && cyc <= n0 + 6)) begin
                errors++;
                $display("FAIL b2b_en c%0d got %b", cyc - n0, en_out);
            end
            if (cyc >= n0 + 3 && cyc <= n0 + 6) begin
                checks++;
                if (alu_out !== exp_v[cyc-n0-3]) begin
                    errors++;
                    $display("FAIL b2b_alu c%0d got %h exp %h",
                             cyc - n0, alu_out, exp_v[cyc-n0-3]);
                end
            end
        end
        dbg_addr = 2'd1; #1;
        checks++;
        if (dbg_data !== 16'h0005) begin
            errors++; $display("FAIL b2b_r1 got %h exp 0005", dbg_data);
        end
        dbg_addr = 2'd2; #1;
        checks++;
        if (dbg_data !== 16'h0003) begin
            errors++; $display("FAIL b2b_r2 got %h exp 0003", dbg_data);
        end
        q_due.delete(); q_res.delete();
    endtask

    task automatic test_pc();
        logic [DW-1:0] exp_pc [6];
        logic          pul [6];
        logic [1:0]    ctl [6];
        logic [7:0]    oa [6];
        exp_pc = '{16'h1, 16'h2, 16'h3, 16'h40, 16'h3E, 16'h3E};
        pul = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ctl = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1};
        oa  = '{8'h00, 8'h00, 8'h00, 8'h40, 8'hFE, 8'h00};
        for (int k = 0; k < 6; k++) begin
            drive_pc(pul[k], ctl[k], oa[k]);
            tick();
            en_pc_pulse = 1'b0;
            checks++;
            if (pc_out !== exp_pc[k]) begin
                errors++;
                $display("FAIL pc_step%0d got %h exp %h", k, pc_out, exp_pc[k]);
            end
        end
    endtask

    task automatic test_wrap_flags();
        int n0;
        n0 = cyc;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: drive_op(2'd1, 2'd0, 1'b1, 1'b1, 8'hFF, 3'b110);
                1: drive_op(2'd1, 2'd0, 1'b1, 1'b1, 8'h01, 3'b000);
                default: en_in = 1'b0;
            endcase
            tick();
            if (cyc == n0 + 3) begin
                checks++;
                if (alu_out !== 16'hFFFF) begin
                    errors++; $display("FAIL wrap_ld got %h exp ffff", alu_out);
                end
            end
            if (cyc == n0 + 4) begin
                checks++;
                if (en_out !== 1'b1 || alu_out !== 16'h0000) begin
                    errors++;
                    $display("FAIL wrap_add got en=%b %h exp en=1 0000",
                             en_out, alu_out);
                end
`ifdef PIPE_DP_FLAGS_EN
                checks++;
                if ({flag_z, flag_c, flag_n} !== 3'b110) begin
                    errors++;
                    $display("FAIL wrap_flags got zcn=%b%b%b exp 110",
                             flag_z, flag_c, flag_n);
                end
`endif
            end
        end
        q_due.delete(); q_res.delete();
    endtask

    task automatic test_random();
        logic exp_en;
        q_due.delete(); q_res.delete();
        for (int k = 0; k < 306; k++) begin
            if (k < 300 && $urandom_range(3) != 0)
                drive_op(2'($urandom_range(3)), 2'($urandom_range(3)),
                         1'($urandom_range(1)), ($urandom_range(3) == 0),
                         8'($urandom), 3'($urandom));
            else begin
                en_in = 1'b0;
                rd = 2'($urandom);
                rs = 2'($urandom);
            end
            if (k < 300)
                drive_pc(($urandom_range(2) == 0), 2'($urandom), 8'($urandom));
            else
                drive_pc(1'b0, 2'd0, 8'h00);
            tick();
            while (q_due.size() > 0 && q_due[0] < cyc) begin
                void'(q_due.pop_front());
                void'(q_res.pop_front());
            end
            exp_en = (q_due.size() > 0) && (q_due[0] == cyc);
            checks++;
            if (en_out !== exp_en) begin
                errors++;
                $display("FAIL rand_en k%0d got %b exp %b", k, en_out, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (alu_out !== q_res[0]) begin
                    errors++;
                    $display("FAIL rand_alu k%0d got %h exp %h",
                             k, alu_out, q_res[0]);
                end
                void'(q_due.pop_front());
                void'(q_res.pop_front());
            end
            checks++;
            if (pc_out !== m_pc) begin
                errors++;
                $display("FAIL rand_pc k%0d got %h exp %h", k, pc_out, m_pc);
            end
        end
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            checks++;
            if (dbg_data !== m_reg[a]) begin
                errors++;
                $display("FAIL rand_reg r%0d got %h exp %h",
                         a, dbg_data, m_reg[a]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        drive_pc(1'b1, 2'd2, 8'h77);
        tick();
        en_pc_pulse = 1'b0;
        drive_op(2'd3, 2'd0, 1'b1, 1'b1, 8'h12, 3'b110);
        tick();
        en_in = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (en_out !== 1'b0 || pc_out !== 16'h0) begin
            errors++;
            $display("FAIL rst_async got en=%b pc=%h exp en=0 pc=0000",
                     en_out, pc_out);
        end
        tick();
        rst_n = 1'b1;
        model_reset();
        dbg_addr = 2'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (en_out !== 1'b0 || pc_out !== 16'h0 || dbg_data !== 16'h0) begin
                errors++;
                $display("FAIL rst_flight k%0d got en=%b pc=%h r3=%h exp 0",
                         k, en_out, pc_out, dbg_data);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en_in = 1'b0; rd = '0; rs = '0; wr_en = 1'b0;
        alu_in_sel = 1'b0; offset = '0; alu_func = '0;
        en_pc_pulse = 1'b0; pc_ctrl = '0; offset_addr = '0; dbg_addr = '0;
        test_reset();
        test_single_pass();
        test_back_to_back();
        test_pc();
        test_wrap_flags();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
